// File: rtl/fp_match_extract.sv
// First-filter match extractor: buffers filter state words and emits one record per
// matching byte lane (any bucket bit cleared), in lane order, with packet byte offsets.
module fp_match_extract #(
  parameter int unsigned FP_DWIDTH  = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POS_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FP_DWIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 buf_almost_full,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POS_WIDTH-1:0] out_pos,
  output logic [7:0]           out_mask,
  output logic                 out_last,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned Lanes = FP_DWIDTH / 8;
  localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e state_q, state_d;

  logic [FP_DWIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                 mem_eop  [FIFO_DEPTH];
  logic [POS_WIDTH-1:0] mem_off  [FIFO_DEPTH];

  logic [AddrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AddrW:0]       count_q, count_d;
  logic [POS_WIDTH-1:0] off_q, off_d, word_off;
  logic [15:0]          drop_q, drop_d;
  logic                 synced_q, synced_d;

  logic [FP_DWIDTH-1:0] w_data_q, w_data_d;
  logic                 w_eop_q, w_eop_d;
  logic [POS_WIDTH-1:0] w_off_q, w_off_d;
  logic [Lanes-1:0]     pend_q, pend_d;

  logic                 empty, full, take, wr, pop, drop, has_data_next;
  logic [FP_DWIDTH-1:0] head_data;
  logic [Lanes-1:0]     head_match, pend_rest;
  logic [LaneW-1:0]     lo_idx;
  logic [7:0]           lane_byte;
  logic                 emit, accept;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AddrW+1)'(FIFO_DEPTH));
  // After reset, words are ignored until a packet start is seen.
  assign take      = in_valid & (in_sop | synced_q);
  assign pop       = (state_q == StLoad) & ~empty;
  assign wr        = take & (~full | pop);
  assign drop      = take & full & ~pop;
  assign word_off  = in_sop ? '0 : off_q;
  assign head_data = mem_data[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign has_data_next = (count_d != '0);
  assign synced_d      = synced_q | (in_valid & in_sop);
  assign off_d         = take ? word_off + POS_WIDTH'(Lanes) : off_q;
  assign drop_d        = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

  always_comb begin
    head_match = '0;
    for (int i = 0; i < Lanes; i++) begin
      head_match[i] = ~&head_data[8*i +: 8];
    end
  end

  // Descending scan leaves the lowest pending lane in lo_idx.
  always_comb begin
    lo_idx = '0;
    for (int i = Lanes - 1; i >= 0; i--) begin
      if (pend_q[i]) lo_idx = LaneW'(i);
    end
  end

  assign lane_byte = w_data_q[8*int'(lo_idx) +: 8];
  assign pend_rest = pend_q & ~(Lanes'(1) << lo_idx);

  assign emit            = (state_q == StEmit) & ~rst;
  assign accept          = emit & out_ready;
  assign out_valid       = emit;
  assign out_pos         = emit ? w_off_q + POS_WIDTH'(lo_idx) : '0;
  assign out_mask        = (emit && pend_q != '0) ? ~lane_byte : 8'h00;
  assign out_last        = emit & w_eop_q & (pend_rest == '0);
  assign buf_almost_full = ~rst & (count_q >= (AddrW+1)'(FIFO_DEPTH - 1));
  assign drop_cnt        = drop_q;

  always_comb begin
    state_d  = state_q;
    w_data_d = w_data_q;
    w_eop_d  = w_eop_q;
    w_off_d  = w_off_q;
    pend_d   = pend_q;
    unique case (state_q)
      StIdle: begin
        if (has_data_next) state_d = StLoad;
      end
      StLoad: begin
        if (!empty) begin
          w_data_d = head_data;
          w_eop_d  = mem_eop[rd_ptr_q];
          w_off_d  = mem_off[rd_ptr_q];
          pend_d   = head_match;
          if (head_match != '0 || mem_eop[rd_ptr_q]) state_d = StEmit;
          else if (!has_data_next)                   state_d = StIdle;
        end else if (!has_data_next) begin
          state_d = StIdle;
        end
      end
      StEmit: begin
        if (accept) begin
          pend_d = pend_rest;
          if (pend_rest == '0) state_d = has_data_next ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_eop[wr_ptr_q]  <= in_eop;
      mem_off[wr_ptr_q]  <= word_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      off_q    <= '0;
      drop_q   <= '0;
      synced_q <= 1'b0;
      w_data_q <= '0;
      w_eop_q  <= 1'b0;
      w_off_q  <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_q <= wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_q  <= count_d;
      off_q    <= off_d;
      drop_q   <= drop_d;
      synced_q <= synced_d;
      w_data_q <= w_data_d;
      w_eop_q  <= w_eop_d;
      w_off_q  <= w_off_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_fp_match_extract.sv
// Bench for fp_match_extract: directed scenarios plus randomized packets, every output
// record checked against a queue of records derived directly from the lane rules.
module tb_fp_match_extract;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid, in_sop, in_eop;
  logic         buf_almost_full;
  logic         out_valid, out_ready;
  logic [15:0]  out_pos;
  logic [7:0]   out_mask;
  logic         out_last;
  logic [15:0]  drop_cnt;

  fp_match_extract dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .buf_almost_full (buf_almost_full),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pos         (out_pos),
    .out_mask        (out_mask),
    .out_last        (out_last),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pos;
    logic [7:0]  mask;
    logic        last;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] m_off;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 1;  // 0 low, 1 high, 2 random, 3 toggle
  logic        stalled = 1'b0;
  rec_t        held;
  logic [127:0] ones;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: one record per lane whose byte is not all ones; a matchless eop word
  // yields a single empty closing record.
  task automatic push_word(input logic [127:0] d, input logic s, input logic e);
    int   cnt;
    int   k;
    rec_t r;
    logic [7:0] b;
    if (s) m_off = 16'd0;
    cnt = 0;
    for (int i = 0; i < 16; i++) if (d[8*i +: 8] != 8'hFF) cnt++;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      b = d[8*i +: 8];
      if (b != 8'hFF) begin
        r.pos  = m_off + 16'(i);
        r.mask = ~b;
        r.last = e && (k == cnt - 1);
        exp_q.push_back(r);
        k++;
      end
    end
    if (e && cnt == 0) begin
      r.pos  = m_off;
      r.mask = 8'h00;
      r.last = 1'b1;
      exp_q.push_back(r);
    end
    m_off = m_off + 16'd16;
  endtask

  function automatic logic [127:0] set_lane(input logic [127:0] w, input int i,
                                            input logic [7:0] b);
    logic [127:0] t;
    t = w;
    t[8*i +: 8] = b;
    return t;
  endfunction

  task automatic cycle(input logic v, input logic [127:0] d, input logic s, input logic e);
    in_valid = v;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = ~out_ready;
    endcase
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 400 && (exp_q.size() != 0 || out_valid); k++) cycle(0, '0, 0, 0);
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (stalled) begin
        check("stable_pos", out_pos, held.pos);
        check("stable_mask", out_mask, held.mask);
        check("stable_last", out_last, held.last);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rec", out_pos, 32'hFFFF_FFFF);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          check("rec_pos", out_pos, r.pos);
          check("rec_mask", out_mask, r.mask);
          check("rec_last", out_last, r.last);
        end
      end
      stalled   = !out_ready;
      held.pos  = out_pos;
      held.mask = out_mask;
      held.last = out_last;
    end else begin
      if (stalled && !rst) check("valid_held", out_valid, 1);
      stalled = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    ones      = '1;
    m_off     = '0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_af", buf_almost_full, 0);
    check("rst_pos", out_pos, 0);
    check("rst_mask", out_mask, 0);
    check("rst_last", out_last, 0);
    check("rst_drop", drop_cnt, 0);
    cycle(0, '0, 0, 0);
    rst = 1'b0;

    // Single-word packet, latency t+2
    rdy_mode = 1;
    w = set_lane(ones, 3, 8'hFE);
    push_word(w, 1, 1);
    cycle(1, w, 1, 1);
    @(negedge clk);
    check("lat_t1", out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_t2", out_valid, 1);
    drain("drain_single");

    // Three-word packet with matches only in the middle word
    push_word(ones, 1, 0);
    cycle(1, ones, 1, 0);
    w = set_lane(set_lane(ones, 0, 8'h7F), 15, 8'h7F);
    push_word(w, 0, 0);
    cycle(1, w, 0, 0);
    push_word(ones, 0, 1);
    cycle(1, ones, 0, 1);
    drain("drain_three");

    // All lanes match, consumer toggling
    rdy_mode = 3;
    push_word('0, 1, 1);
    cycle(1, '0, 1, 1);
    drain("drain_toggle");

    // Overflow with consumer stalled: word 5 is the one dropped
    rdy_mode = 0;
    for (int k = 0; k < 6; k++) begin
      w = set_lane(ones, k, 8'hFE);
      if (k < 5) push_word(w, k == 0, k == 5);
      cycle(1, w, k == 0, k == 5);
    end
    check("ovf_almost_full", buf_almost_full, 1);
    check("ovf_drop_cnt", drop_cnt, 1);
    rdy_mode = 1;
    drain("drain_ovf");
    check("ovf_drop_hold", drop_cnt, 1);

    // Reset while emitting with five lanes pending
    rdy_mode = 0;
    w = ones;
    for (int i = 0; i < 5; i++) w = set_lane(w, i, 8'h00);
    push_word(w, 1, 1);
    cycle(1, w, 1, 1);
    for (int k = 0; k < 10 && !out_valid; k++) cycle(0, '0, 0, 0);
    check("pre_rst_emit", out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("in_rst_valid", out_valid, 0);
    check("in_rst_mask", out_mask, 0);
    check("in_rst_pos", out_pos, 0);
    check("in_rst_af", buf_almost_full, 0);
    cycle(0, '0, 0, 0);
    rst = 1'b0;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_drop", drop_cnt, 0);
    rdy_mode = 1;
    cycle(1, set_lane(ones, 0, 8'h00), 0, 1);  // mid-packet word, must be ignored
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    w = set_lane(ones, 2, 8'h7F);
    push_word(w, 1, 1);
    cycle(1, w, 1, 1);
    drain("drain_post_rst");

    // Randomized packets, paced on buf_almost_full so nothing is dropped
    rdy_mode = 2;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(5, 1);
      for (int j = 0; j < len; j++) begin
        for (int k = 0; k < 100 && buf_almost_full; k++) cycle(0, '0, 0, 0);
        if (buf_almost_full) check("pace_timeout", buf_almost_full, 0);
        for (int i = 0; i < 16; i++) begin
          logic [7:0] b;
          b = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'hFF;
          w[8*i +: 8] = b;
        end
        push_word(w, j == 0, j == len - 1);
        cycle(1, w, j == 0, j == len - 1);
        if ($urandom_range(3) == 0) cycle(0, '0, 0, 0);
      end
    end
    rdy_mode = 1;
    drain("drain_random");
    check("random_drop_cnt", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
